// File: rtl/reg_bank_arbiter_if.sv
// Requester/register-bank signal bundle for reg_bank_arbiter.
// The master side drives requests; the slave side (the arbiter) drives the bank controls.
interface reg_bank_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int NREG = 4
);
  localparam int AW = $clog2(NREG);

  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] wr_addr;
  logic [NREQ*W-1:0]  wr_data;
  logic               clr_req;
  logic [NREQ-1:0]    gnt;
  logic               clr_ack;
  logic [NREG-1:0]    reg_en;
  logic [W-1:0]       reg_d;
  logic               reg_clr;
  logic               busy;

  modport master (
    output req, wr_addr, wr_data, clr_req,
    input  gnt, clr_ack, reg_en, reg_d, reg_clr, busy
  );

  modport slave (
    input  req, wr_addr, wr_data, clr_req,
    output gnt, clr_ack, reg_en, reg_d, reg_clr, busy
  );
endinterface

// File: rtl/reg_bank_arbiter.sv
// Round-robin write-port arbiter and clear sequencer for a bank of registers.
// Every bank control is a flop output, so the registers see glitch-free en/d/clr.
//
// state | meaning
// IDLE  | sample clr_req/req and pick the next action
// WRITE | one-cycle write pulse (gnt, reg_en, reg_d) for the winner
// CLEAR | one-cycle bank clear (reg_clr, clr_ack)
module reg_bank_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int NREG = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  reg_bank_arbiter_if.slave bus
);
  localparam int AW = $clog2(NREG);
  localparam int PW = $clog2(NREQ);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] CLEAR = 2'd2;

  logic [1:0]      state;
  logic [PW-1:0]   ptr;
  logic [NREQ-1:0] gnt_q;
  logic            clr_ack_q;
  logic [NREG-1:0] reg_en_q;
  logic [W-1:0]    reg_d_q;
  logic            reg_clr_q;

  logic            win_vld;
  logic [PW-1:0]   win;
  logic [PW-1:0]   ptr_next;
  logic [AW-1:0]   addr_k;
  logic [W-1:0]    data_k;
  logic [NREQ-1:0] gnt_next;
  logic [NREG-1:0] en_next;

  // Search starts at ptr and wraps, so the first hit is the round-robin winner.
  always_comb begin : arb
    int j;
    j        = 0;
    win_vld  = 1'b0;
    win      = '0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!win_vld && bus.req[j]) begin
        win_vld = 1'b1;
        win     = PW'(j);
      end
    end
  end

  always_comb begin
    addr_k   = bus.wr_addr[int'(win)*AW +: AW];
    data_k   = bus.wr_data[int'(win)*W +: W];
    ptr_next = (int'(win) == NREQ - 1) ? '0 : win + PW'(1);
    gnt_next = '0;
    gnt_next[win] = 1'b1;
    // Out-of-range addresses still get a grant but enable nothing.
    en_next  = '0;
    if (int'(addr_k) < NREG) en_next[addr_k] = 1'b1;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt_q     <= '0;
      clr_ack_q <= 1'b0;
      reg_en_q  <= '0;
      reg_d_q   <= '0;
      reg_clr_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.clr_req) begin
            state     <= CLEAR;
            reg_clr_q <= 1'b1;
            clr_ack_q <= 1'b1;
          end else if (win_vld) begin
            state    <= WRITE;
            gnt_q    <= gnt_next;
            reg_en_q <= en_next;
            reg_d_q  <= data_k;
            ptr      <= ptr_next;
          end
        end
        default: begin
          state     <= IDLE;
          gnt_q     <= '0;
          reg_en_q  <= '0;
          reg_clr_q <= 1'b0;
          clr_ack_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.clr_ack = clr_ack_q;
  assign bus.reg_en  = reg_en_q;
  assign bus.reg_d   = reg_d_q;
  assign bus.reg_clr = reg_clr_q;
  assign bus.busy    = (state != IDLE);
endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed self-checking bench for reg_bank_arbiter (NREG=4 main instance, NREG=3 boundary instance).
module tb_reg_bank_arbiter;
  logic clk;
  logic clr_n;
  int   checks;
  int   errors;

  reg_bank_arbiter_if #(.NREQ(4), .W(8), .NREG(4)) bus  ();
  reg_bank_arbiter_if #(.NREQ(4), .W(8), .NREG(3)) bus3 ();

  reg_bank_arbiter #(.NREQ(4), .W(8), .NREG(4)) dut  (.clk(clk), .clr_n(clr_n), .bus(bus));
  reg_bank_arbiter #(.NREQ(4), .W(8), .NREG(3)) dut3 (.clk(clk), .clr_n(clr_n), .bus(bus3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural register bank fed by the main instance.
  logic [7:0] q [4];
  always @(posedge clk or posedge bus.reg_clr) begin
    if (bus.reg_clr) begin
      for (int i = 0; i < 4; i++) q[i] <= 8'h00;
    end else begin
      for (int i = 0; i < 4; i++) if (bus.reg_en[i]) q[i] <= bus.reg_d;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_wr(input int k, input logic [1:0] a, input logic [7:0] d);
    bus.wr_addr[k*2 +: 2] = a;
    bus.wr_data[k*8 +: 8] = d;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clr_n  = 1'b0;
    bus.req     = 4'($urandom);
    bus.wr_addr = 8'($urandom);
    bus.wr_data = 32'($urandom);
    bus.clr_req = 1'($urandom);
    bus3.req     = '0;
    bus3.wr_addr = '0;
    bus3.wr_data = '0;
    bus3.clr_req = 1'b0;

    // Reset with random inputs
    step(); step();
    check("rst_gnt",     32'(bus.gnt),     32'h0);
    check("rst_reg_en",  32'(bus.reg_en),  32'h0);
    check("rst_reg_d",   32'(bus.reg_d),   32'h0);
    check("rst_reg_clr", 32'(bus.reg_clr), 32'h0);
    check("rst_clr_ack", 32'(bus.clr_ack), 32'h0);
    check("rst_busy",    32'(bus.busy),    32'h0);
    bus.req = '0; bus.clr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    clr_n = 1'b1;
    step(); step();
    check("idle_gnt",  32'(bus.gnt),  32'h0);
    check("idle_busy", 32'(bus.busy), 32'h0);

    // Single write: requester 0 -> register 2 = A5
    set_wr(0, 2'd2, 8'hA5);
    bus.req = 4'b0001;
    step();
    check("wr_gnt",    32'(bus.gnt),    32'b0001);
    check("wr_reg_en", 32'(bus.reg_en), 32'b0100);
    check("wr_reg_d",  32'(bus.reg_d),  32'hA5);
    check("wr_busy",   32'(bus.busy),   32'h1);
    bus.req = '0;
    step();
    check("wr_end_gnt",    32'(bus.gnt),    32'h0);
    check("wr_end_reg_en", 32'(bus.reg_en), 32'h0);
    check("wr_end_busy",   32'(bus.busy),   32'h0);
    check("wr_q2",         32'(q[2]),       32'hA5);
    check("wr_hold_d",     32'(bus.reg_d),  32'hA5);

    // Pointer: grant 1, then req=0011 must go to 0 (search 2,3,0)
    set_wr(1, 2'd1, 8'h11);
    bus.req = 4'b0010;
    step();
    check("ptr_g1", 32'(bus.gnt), 32'b0010);
    bus.req = '0;
    step();
    set_wr(0, 2'd3, 8'h33);
    set_wr(1, 2'd0, 8'h44);
    bus.req = 4'b0011;
    step();
    check("ptr_wrap_gnt",    32'(bus.gnt),    32'b0001);
    check("ptr_wrap_reg_en", 32'(bus.reg_en), 32'b1000);
    check("ptr_wrap_reg_d",  32'(bus.reg_d),  32'h33);
    bus.req = 4'b0010;
    step();
    check("ptr_gap_gnt", 32'(bus.gnt), 32'h0);
    step();
    check("ptr_next_gnt",   32'(bus.gnt),   32'b0010);
    check("ptr_next_reg_d", 32'(bus.reg_d), 32'h44);
    bus.req = '0;
    step();
    check("q1_val", 32'(q[1]), 32'h11);
    check("q3_val", 32'(q[3]), 32'h33);
    check("q0_val", 32'(q[0]), 32'h44);

    // NREG=3 boundary on second instance
    bus3.wr_addr[1:0] = 2'd3;
    bus3.wr_data[7:0] = 8'h5A;
    bus3.req = 4'b0001;
    step();
    check("b3_gnt",    32'(bus3.gnt),    32'b0001);
    check("b3_reg_en", 32'(bus3.reg_en), 32'b000);
    check("b3_busy",   32'(bus3.busy),   32'h1);
    bus3.req = '0;
    step();
    bus3.wr_addr[1:0] = 2'd2;
    bus3.req = 4'b0001;
    step();
    check("b3_ok_reg_en", 32'(bus3.reg_en), 32'b100);
    bus3.req = '0;
    step();

    // Reset mid-WRITE aborts immediately and returns the pointer to 0
    set_wr(1, 2'd2, 8'h77);
    bus.req = 4'b0010;
    step();
    check("abort_pre_gnt", 32'(bus.gnt), 32'b0010);
    bus.req = '0;
    #2 clr_n = 1'b0;
    #1;
    check("abort_gnt",    32'(bus.gnt),    32'h0);
    check("abort_reg_en", 32'(bus.reg_en), 32'h0);
    check("abort_busy",   32'(bus.busy),   32'h0);
    check("abort_reg_d",  32'(bus.reg_d),  32'h0);
    step();
    clr_n = 1'b1;
    step();
    bus.req = 4'b1010;
    step();
    check("abort_ptr0_gnt", 32'(bus.gnt), 32'b0010);
    bus.req = '0;
    step();

    // Reset again so fairness starts at pointer 0
    clr_n = 1'b0;
    step();
    clr_n = 1'b1;
    step();
    for (int k = 0; k < 4; k++) set_wr(k, 2'(k), 8'(8'h10 + k));
    bus.req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      step();
      check($sformatf("fair_gnt%0d", n),   32'(bus.gnt),    32'(4'b0001 << (n % 4)));
      check($sformatf("fair_d%0d", n),     32'(bus.reg_d),  32'(8'h10 + (n % 4)));
      bus.req[n % 4] = 1'b0;
      step();
      check($sformatf("fair_gap%0d", n),   32'(bus.gnt),    32'h0);
      bus.req[n % 4] = 1'b1;
    end
    bus.req = '0;
    step();

    // Clear has priority over a simultaneous request (pointer now 1)
    bus.clr_req = 1'b1;
    bus.req     = 4'b0100;
    step();
    check("pri_reg_clr", 32'(bus.reg_clr), 32'h1);
    check("pri_clr_ack", 32'(bus.clr_ack), 32'h1);
    check("pri_gnt",     32'(bus.gnt),     32'h0);
    check("pri_busy",    32'(bus.busy),    32'h1);
    check("pri_q2_clr",  32'(q[2]),        32'h0);
    bus.clr_req = 1'b0;
    step();
    check("pri_gap_clr", 32'(bus.reg_clr), 32'h0);
    check("pri_gap_gnt", 32'(bus.gnt),     32'h0);
    step();
    check("pri_gnt2",    32'(bus.gnt),     32'b0100);
    bus.req = '0;
    step();

    // clr_req raised during WRITE waits for the next IDLE
    bus.req = 4'b0001;
    step();
    check("wait_gnt", 32'(bus.gnt), 32'b0001);
    bus.req     = '0;
    bus.clr_req = 1'b1;
    step();
    check("wait_idle_clr", 32'(bus.reg_clr), 32'h0);
    step();
    check("wait_clr",     32'(bus.reg_clr), 32'h1);
    check("wait_clr_ack", 32'(bus.clr_ack), 32'h1);
    bus.clr_req = 1'b0;
    step();
    check("wait_done_clr", 32'(bus.reg_clr), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_bank_arbiter.md
# reg_bank_arbiter

Write-port arbiter and sequencer for a bank of `register` instances. It shares a single write path to NREG W-bit registers among NREQ requesters using round-robin arbitration. It also sequences a bank-wide clear on request. It drives each register's `en`, `d` and `clr` pins from flops, so the bank sees glitch-free control.

## Interface
- `NREQ`, 4, number of requesters (≥2)
- `W`, 8, register data width
- `NREG`, 4, number of registers in the bank (≥2); AW = $clog2(NREG) is derived, not a parameter
- `clk`  in  1  single clock, rising edge
- `clr_n`  in  1  reset, asynchronous, active-low
- `req`  in  NREQ  per-requester write request, level
- `wr_addr`  in  NREQ*AW  packed target addresses, requester i at [i*AW +: AW]
- `wr_data`  in  NREQ*W  packed write data, requester i at [i*W +: W]
- `clr_req`  in  1  bank-clear request, level
- `gnt`  out  NREQ  one-hot grant pulse, registered
- `clr_ack`  out  1  clear-done pulse, registered
- `reg_en`  out  NREG  one-hot enable to register bank, registered
- `reg_d`  out  W  shared data to all register `d` inputs, registered
- `reg_clr`  out  1  bank clear, drives every register `clr`, registered
- `busy`  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, WRITE, CLEAR.
- Arbitration and decisions happen only in IDLE, at the rising edge.
- IDLE:
  - If `clr_req`=1 → CLEAR. Clear has priority over every `req`.
  - Else, if any `req` bit is set → WRITE with winner k.
  - Else → stay in IDLE.
- Round-robin pointer p (0..NREQ-1):
  - Winner k is the first set `req` bit found searching p, p+1, …, NREQ-1, 0, …, p-1.
  - On a grant, p ← (k+1) mod NREQ. p is unchanged otherwise.
- Entering WRITE, the following are registered from requester k:
  - `gnt`[k]=1.
  - `reg_d`=wr_data[k].
  - `reg_en`=one-hot(wr_addr[k]).
- Address rule: if wr_addr[k] ≥ NREG, `reg_en` is all-zero, `gnt`[k] still pulses, the data is dropped and p still advances.
- WRITE lasts exactly 1 cycle, then → IDLE. In IDLE, `gnt`=0 and `reg_en`=0.
- `reg_d` holds its last value outside WRITE. This is harmless because `en`=0.
- CLEAR lasts exactly 1 cycle with `reg_clr`=1 and `clr_ack`=1, then → IDLE. p is unchanged.
- `clr_req` arriving during WRITE waits and is taken in the following IDLE cycle.
- Requester handshake:
  - Assert `req` and hold `wr_addr`/`wr_data` stable until `gnt` is seen high.
  - Deassert `req` on the edge that ends the `gnt` cycle. A `req` still high one cycle after `gnt` counts as a new request.
  - `req` must not be withdrawn before `gnt`. Behaviour if it is withdrawn: the request is simply not granted if it is low at the IDLE sampling edge.
- The clear requester deasserts `clr_req` on the edge ending `clr_ack`, under the same rule.
- Reset (`clr_n`=0, asynchronous):
  - State IDLE, p=0.
  - `gnt`=0, `clr_ack`=0, `reg_en`=0, `reg_d`=0, `reg_clr`=0, `busy`=0.
  - Reset asserted mid-WRITE or mid-CLEAR aborts immediately. No write or clear pulse survives.

## Timing
- `req` high at edge t (state IDLE) → `gnt`, `reg_en`, `reg_d` valid during cycle t..t+1. The register captures at edge t+1, so its `q` shows the new value after edge t+1.
- Latency from request to register update: 2 edges.
- Maximum throughput is one write per 2 cycles, due to the mandatory IDLE between grants.
- `clr_req` high at edge t (IDLE) → `reg_clr`=1 during cycle t..t+1. The register `q` clears asynchronously during that cycle.
- `busy` is high exactly in the WRITE/CLEAR cycles.
- With all NREQ requests held continuously, each requester is granted once every 2*NREQ cycles.
- All outputs are flop outputs with no combinational path from inputs.

## Test plan
- Reset: `clr_n`=0 with random inputs → `gnt`=0, `reg_en`=0, `reg_d`=0, `reg_clr`=0, `busy`=0. After release with `req`=0, outputs stay 0.
- Single write: `req`=0001, addr0=2, data0=0xA5 → next cycle `gnt`=0001, `reg_en`=0100, `reg_d`=0xA5, `busy`=1, for exactly 1 cycle. Register 2 `q`=0xA5 after the following edge.
- Fairness: `req`=1111 held, each requester releasing and re-raising after its grant → grant order 0,1,2,3,0, with each `gnt` 2 cycles apart.
- Pointer: after requester 1 is granted, `req`=0011 → requester 0 is granted next (search starts at 2, wraps).
- Priority: `clr_req`=1 and `req`=0100 at the same edge → CLEAR cycle first (`reg_clr`=1, `clr_ack`=1, `gnt`=0), then requester 2 is granted 2 cycles later.
- Boundary:
  - NREG=3, requester 0 writes addr=3 → `gnt`=0001 pulses with `reg_en`=000.
  - `clr_n` dropped during a WRITE cycle → `reg_en`/`gnt` go to 0 asynchronously, and p=0 after release.
